// File: rtl/mult_share_arbiter.sv
// -----------------------------------------------------------------------------
// mult_share_arbiter
//
// Round-robin arbiter and sequencer that time-shares one sequential 8x8
// multiplier among NREQ requesters. The winning requester's operands are
// captured in IDLE, a single load strobe is issued in LOAD, and WAIT holds
// until the multiplier raises its ready flag or a watchdog expires. DONE
// returns the product (or zero with err on an abort) with a one-cycle done
// pulse to the winner, then advances the round-robin pointer past it.
//
// Ports
//   clk       system clock
//   reset     synchronous active-high reset
//   req       per-requester request level, held until the matching done
//   op_a      operand A, requester i on bits [8i+7:8i]
//   op_b      operand B, same packing
//   gnt       one-hot grant, high from LOAD through DONE
//   done      one-cycle result-valid pulse for the granted requester
//   res       product of the last operation, held until the next DONE
//   err       one-cycle pulse alongside done when the watchdog aborted
//   busy      high whenever the sequencer is not idle
//   mult_ld   one-cycle load strobe to the multiplier
//   mult_a    registered operand A to the multiplier
//   mult_b    registered operand B to the multiplier
//   mult_rdy  multiplier result-valid flag
//   mult_res  multiplier product
// -----------------------------------------------------------------------------
module mult_share_arbiter #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned TIMEOUT = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NREQ-1:0]     req,
    input  logic [8*NREQ-1:0]   op_a,
    input  logic [8*NREQ-1:0]   op_b,
    output logic [NREQ-1:0]     gnt,
    output logic [NREQ-1:0]     done,
    output logic [15:0]         res,
    output logic                err,
    output logic                busy,
    output logic                mult_ld,
    output logic [7:0]          mult_a,
    output logic [7:0]          mult_b,
    input  logic                mult_rdy,
    input  logic [15:0]         mult_res
);

    localparam int unsigned PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned SUM_W = PTR_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [NREQ-1:0]    gnt_q,   gnt_d;
    logic [NREQ-1:0]    done_q,  done_d;
    logic [15:0]        res_q,   res_d;
    logic               err_q,   err_d;
    logic               busy_q,  busy_d;
    logic               ld_q,    ld_d;
    logic [7:0]         a_q,     a_d;
    logic [7:0]         b_q,     b_d;
    logic [PTR_W-1:0]   ptr_q,   ptr_d;
    logic [PTR_W-1:0]   win_q,   win_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;

    logic               arb_found_c;
    logic [PTR_W-1:0]   arb_idx_c;
    logic [7:0]         sel_a_c;
    logic [7:0]         sel_b_c;
    logic [NREQ-1:0]    sel_oh_c;

    // Round-robin scan: first set request at or above the pointer, wrapping.
    // The sum is one bit wider so the wrap compare works for any NREQ.
    always_comb begin
        logic [SUM_W-1:0] idx;
        arb_found_c = 1'b0;
        arb_idx_c   = '0;
        idx         = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            idx = {1'b0, ptr_q} + SUM_W'(i);
            if (idx >= SUM_W'(NREQ)) begin
                idx = idx - SUM_W'(NREQ);
            end
            if (!arb_found_c && req[idx[PTR_W-1:0]]) begin
                arb_found_c = 1'b1;
                arb_idx_c   = idx[PTR_W-1:0];
            end
        end
    end

    // Operand and one-hot grant selection for the scan winner.
    always_comb begin
        sel_a_c  = '0;
        sel_b_c  = '0;
        sel_oh_c = '0;
        for (int unsigned j = 0; j < NREQ; j++) begin
            if (arb_idx_c == PTR_W'(j)) begin
                sel_a_c     = op_a[8*j +: 8];
                sel_b_c     = op_b[8*j +: 8];
                sel_oh_c[j] = 1'b1;
            end
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        done_d  = '0;
        res_d   = res_q;
        err_d   = 1'b0;
        ld_d    = 1'b0;
        a_d     = a_q;
        b_d     = b_q;
        ptr_d   = ptr_q;
        win_d   = win_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            ST_IDLE: begin
                if (arb_found_c) begin
                    win_d   = arb_idx_c;
                    a_d     = sel_a_c;
                    b_d     = sel_b_c;
                    gnt_d   = sel_oh_c;
                    ld_d    = 1'b1;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                // Any ready seen here belongs to the previous operation.
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (mult_rdy) begin
                    res_d   = mult_res;
                    done_d  = gnt_q;
                    state_d = ST_DONE;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    res_d   = '0;
                    err_d   = 1'b1;
                    done_d  = gnt_q;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                gnt_d   = '0;
                ptr_d   = (win_q == PTR_W'(NREQ - 1)) ? '0 : win_q + PTR_W'(1);
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            done_q  <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            ld_q    <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            ptr_q   <= '0;
            win_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            res_q   <= res_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            ld_q    <= ld_d;
            a_q     <= a_d;
            b_q     <= b_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
            cnt_q   <= cnt_d;
        end
    end

    assign gnt     = gnt_q;
    assign done    = done_q;
    assign res     = res_q;
    assign err     = err_q;
    assign busy    = busy_q;
    assign mult_ld = ld_q;
    assign mult_a  = a_q;
    assign mult_b  = b_q;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mult_share_arbiter
//
// Drives mult_share_arbiter with directed and randomized requests against a
// behavioural multiplier with programmable latency, and checks grant order,
// results, error flags and latency against a round-robin reference model.
// -----------------------------------------------------------------------------
module tb_mult_share_arbiter;

    localparam int unsigned NREQ    = 4;
    localparam int unsigned TIMEOUT = 32;

    logic                clk = 1'b0;
    logic                reset;
    logic [NREQ-1:0]     req;
    logic [8*NREQ-1:0]   op_a;
    logic [8*NREQ-1:0]   op_b;
    logic [NREQ-1:0]     gnt;
    logic [NREQ-1:0]     done;
    logic [15:0]         res;
    logic                err;
    logic                busy;
    logic                mult_ld;
    logic [7:0]          mult_a;
    logic [7:0]          mult_b;
    logic                mult_rdy = 1'b0;
    logic [15:0]         mult_res = 16'h0;

    mult_share_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .op_a     (op_a),
        .op_b     (op_b),
        .gnt      (gnt),
        .done     (done),
        .res      (res),
        .err      (err),
        .busy     (busy),
        .mult_ld  (mult_ld),
        .mult_a   (mult_a),
        .mult_b   (mult_b),
        .mult_rdy (mult_rdy),
        .mult_res (mult_res)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NREQ-1:0] v;
        logic [15:0]     r;
        logic            e;
        int              c;
    } done_rec_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        int         c;
    } ld_rec_t;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    done_rec_t dq[$];
    ld_rec_t   lq[$];

    // Multiplier model knobs
    int          m_lat   = 4;
    bit          m_never = 1'b0;
    bit          m_stale = 1'b0;
    bit          m_force = 1'b0;
    logic [15:0] m_val   = 16'h0;
    logic [7:0]  la, lb;
    int          cd = 0;

    // Reference state
    int          ref_ptr = 0;
    logic [7:0]  ta [NREQ];
    logic [7:0]  tb_b [NREQ];

    always @(posedge clk) cyc <= cyc + 1;

    // Event recorder, sampled shortly after each edge
    always @(posedge clk) begin
        #1;
        if (!reset) begin
            if (mult_ld) lq.push_back('{a: mult_a, b: mult_b, c: cyc});
            if (|done)   dq.push_back('{v: done, r: res, e: err, c: cyc});
        end
    end

    // Behavioural sequential multiplier: ready m_lat cycles after the load
    always @(negedge clk) begin
        if (reset) begin
            mult_rdy = 1'b0;
            cd       = 0;
        end else begin
            mult_rdy = 1'b0;
            if (mult_ld) begin
                la = mult_a;
                lb = mult_b;
                cd = m_lat;
                if (m_stale) begin
                    mult_rdy = 1'b1;
                    mult_res = 16'hDEAD;
                end
            end else if (cd > 0) begin
                cd = cd - 1;
                if (cd == 0 && !m_never) begin
                    mult_rdy = 1'b1;
                    mult_res = m_force ? m_val : 16'(la) * 16'(lb);
                end
            end
        end
    end

    function automatic int ref_pick(input logic [NREQ-1:0] m);
        for (int k = 0; k < NREQ; k++) begin
            if (m[(ref_ptr + k) % NREQ]) return (ref_ptr + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic logic [NREQ-1:0] onehot(input int i);
        logic [NREQ-1:0] v;
        v = '0;
        if (i >= 0) v[i] = 1'b1;
        return v;
    endfunction

    task automatic rand_ops();
        for (int i = 0; i < NREQ; i++) begin
            ta[i]   = 8'($urandom);
            tb_b[i] = 8'($urandom);
            op_a[8*i +: 8] = ta[i];
            op_b[8*i +: 8] = tb_b[i];
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        req   = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        dq.delete();
        lq.delete();
        ref_ptr = 0;
    endtask

    // Waits for a done record, then one more cycle; returns what was seen.
    task automatic serve(input int budget, output bit ok, output int nd, output int nl,
                         output done_rec_t d, output ld_rec_t l);
        int k;
        ok = 1'b0;
        nd = 0;
        nl = 0;
        d  = '{v: '0, r: '0, e: 1'b0, c: 0};
        l  = '{a: '0, b: '0, c: 0};
        k  = 0;
        while (!ok && k < budget) begin
            @(negedge clk);
            if (dq.size() > 0) ok = 1'b1;
            k++;
        end
        if (ok) begin
            @(negedge clk);
            nd = dq.size();
            nl = lq.size();
            d  = dq.pop_front();
            if (lq.size() > 0) l = lq.pop_front();
            dq.delete();
            lq.delete();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req   = '0;
        op_a  = '0;
        op_b  = '0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({gnt, done, err, busy, mult_ld} !== '0) begin
            miscompares++;
            $display("FAIL reset_ctrl: gnt=%b done=%b err=%b busy=%b ld=%b, want all 0", gnt, done, err, busy, mult_ld);
        end
        vectors++;
        if ({res, mult_a, mult_b} !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_data: res=%h a=%h b=%h, want 0", res, mult_a, mult_b);
        end
        reset = 1'b0;
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_idle_busy: got %b want 0", busy);
        end
        ref_ptr = 0;
        dq.delete();
        lq.delete();
    endtask

    task automatic test_single();
        bit ok; int nd, nl; done_rec_t d; ld_rec_t l;
        rand_ops();
        ta[0] = 8'h12; tb_b[0] = 8'h34;
        op_a[7:0] = 8'h12; op_b[7:0] = 8'h34;
        m_lat = 8;
        req = 4'b0001;
        @(negedge clk);
        vectors++;
        if ({mult_ld, gnt, busy, mult_a, mult_b} !== {1'b1, 4'b0001, 1'b1, 8'h12, 8'h34}) begin
            miscompares++;
            $display("FAIL single_load: ld=%b gnt=%b busy=%b a=%h b=%h, want 1 0001 1 12 34", mult_ld, gnt, busy, mult_a, mult_b);
        end
        serve(100, ok, nd, nl, d, l);
        req = '0;
        vectors++;
        if (!ok || nd != 1 || nl != 1) begin
            miscompares++;
            $display("FAIL single_events: ok=%0d done_pulses=%0d loads=%0d, want 1 1 1", ok, nd, nl);
        end
        vectors++;
        if (d.v !== 4'b0001 || d.r !== 16'h03A8 || d.e !== 1'b0) begin
            miscompares++;
            $display("FAIL single_result: done=%b res=%h err=%b, want 0001 03a8 0", d.v, d.r, d.e);
        end
        vectors++;
        if (d.c - l.c != 9) begin
            miscompares++;
            $display("FAIL single_latency: got %0d want 9", d.c - l.c);
        end
        ref_ptr = 1;
        repeat (3) @(negedge clk);
        vectors++;
        if (res !== 16'h03A8 || done !== '0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL single_hold: res=%h done=%b busy=%b, want 03a8 0000 0", res, done, busy);
        end
    endtask

    task automatic test_simultaneous();
        bit ok; int nd, nl, exp, lat; done_rec_t d; ld_rec_t l;
        do_reset();
        op_a = {NREQ{8'hFF}};
        op_b = {NREQ{8'hFF}};
        req  = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            lat   = $urandom_range(1, 6);
            m_lat = lat;
            exp   = ref_pick(req);
            serve(100, ok, nd, nl, d, l);
            if (n == 4) req = '0;
            vectors++;
            if (!ok || nd != 1 || nl != 1 || d.v !== onehot(exp)) begin
                miscompares++;
                $display("FAIL simul_order[%0d]: done=%b pulses=%0d loads=%0d, want %b 1 1", n, d.v, nd, nl, onehot(exp));
            end
            vectors++;
            if (d.r !== 16'hFE01 || d.e !== 1'b0 || d.c - l.c != lat + 1) begin
                miscompares++;
                $display("FAIL simul_res[%0d]: res=%h err=%b lat=%0d, want fe01 0 %0d", n, d.r, d.e, d.c - l.c, lat + 1);
            end
            ref_ptr = (exp + 1) % NREQ;
        end
    endtask

    task automatic test_fairness();
        bit ok; int nd, nl, exp; done_rec_t d; ld_rec_t l;
        logic [NREQ-1:0] masks [4];
        masks = '{4'b0101, 4'b0101, 4'b0001, 4'b0001};
        do_reset();
        for (int n = 0; n < 4; n++) begin
            req = masks[n];
            rand_ops();
            m_lat = $urandom_range(1, 5);
            exp = ref_pick(req);
            serve(100, ok, nd, nl, d, l);
            if (n == 3) req = '0;
            vectors++;
            if (!ok || d.v !== onehot(exp) || d.r !== 16'(ta[exp]) * 16'(tb_b[exp]) || nl != 1) begin
                miscompares++;
                $display("FAIL fair[%0d]: done=%b res=%h loads=%0d, want %b %h 1", n, d.v, d.r, nl, onehot(exp), 16'(ta[exp]) * 16'(tb_b[exp]));
            end
            ref_ptr = (exp + 1) % NREQ;
        end
    endtask

    task automatic test_timeout();
        bit ok; int nd, nl, exp; done_rec_t d; ld_rec_t l;
        rand_ops();
        m_never = 1'b1;
        req = 4'b0010;
        exp = ref_pick(req);
        serve(200, ok, nd, nl, d, l);
        vectors++;
        if (!ok || d.v !== onehot(exp) || d.e !== 1'b1 || d.r !== 16'h0) begin
            miscompares++;
            $display("FAIL timeout_abort: done=%b err=%b res=%h, want %b 1 0000", d.v, d.e, d.r, onehot(exp));
        end
        vectors++;
        if (d.c - l.c != TIMEOUT + 1 || err !== 1'b0 || nd != 1) begin
            miscompares++;
            $display("FAIL timeout_timing: lat=%0d err_now=%b pulses=%0d, want %0d 0 1", d.c - l.c, err, nd, TIMEOUT + 1);
        end
        ref_ptr = (exp + 1) % NREQ;
        m_never = 1'b0;
        // Ready arriving on the final watchdog cycle must win
        m_lat = TIMEOUT;
        req = 4'b1000;
        exp = ref_pick(req);
        serve(200, ok, nd, nl, d, l);
        vectors++;
        if (!ok || d.v !== onehot(exp) || d.e !== 1'b0 || d.r !== 16'(ta[exp]) * 16'(tb_b[exp]) || d.c - l.c != TIMEOUT + 1) begin
            miscompares++;
            $display("FAIL timeout_edge_ready: done=%b err=%b res=%h lat=%0d, want %b 0 %h %0d", d.v, d.e, d.r, d.c - l.c, onehot(exp), 16'(ta[exp]) * 16'(tb_b[exp]), TIMEOUT + 1);
        end
        ref_ptr = (exp + 1) % NREQ;
        m_lat = 3;
        req = 4'b0001;
        exp = ref_pick(req);
        serve(100, ok, nd, nl, d, l);
        req = '0;
        vectors++;
        if (!ok || d.v !== onehot(exp) || d.e !== 1'b0 || d.r !== 16'(ta[exp]) * 16'(tb_b[exp])) begin
            miscompares++;
            $display("FAIL timeout_recover: done=%b err=%b res=%h, want %b 0 %h", d.v, d.e, d.r, onehot(exp), 16'(ta[exp]) * 16'(tb_b[exp]));
        end
        ref_ptr = (exp + 1) % NREQ;
    endtask

    task automatic test_stale_ready();
        bit ok; int nd, nl, exp; done_rec_t d; ld_rec_t l;
        rand_ops();
        m_stale = 1'b1;
        m_force = 1'b1;
        m_val   = 16'h1234;
        m_lat   = 5;
        req = 4'b0100;
        exp = ref_pick(req);
        serve(100, ok, nd, nl, d, l);
        req = '0;
        m_stale = 1'b0;
        m_force = 1'b0;
        vectors++;
        if (!ok || d.v !== onehot(exp) || d.r !== 16'h1234 || d.e !== 1'b0) begin
            miscompares++;
            $display("FAIL stale_result: done=%b res=%h err=%b, want %b 1234 0", d.v, d.r, d.e, onehot(exp));
        end
        vectors++;
        if (d.c - l.c != 6) begin
            miscompares++;
            $display("FAIL stale_latency: got %0d want 6", d.c - l.c);
        end
        ref_ptr = (exp + 1) % NREQ;
    endtask

    task automatic test_reset_mid_wait();
        bit ok; int nd, nl, exp; done_rec_t d; ld_rec_t l;
        rand_ops();
        m_lat = 3;
        req = 4'b0100;
        exp = ref_pick(req);
        serve(100, ok, nd, nl, d, l);
        ref_ptr = (exp + 1) % NREQ;
        // Second operation on the same channel, aborted by reset in WAIT
        m_lat = 20;
        repeat (6) @(negedge clk);
        vectors++;
        if (gnt !== 4'b0100 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL rstwait_inflight: gnt=%b busy=%b, want 0100 1", gnt, busy);
        end
        req   = '0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        vectors++;
        if (gnt !== '0 || busy !== 1'b0 || done !== '0 || mult_ld !== 1'b0) begin
            miscompares++;
            $display("FAIL rstwait_clear: gnt=%b busy=%b done=%b ld=%b, want 0000 0 0000 0", gnt, busy, done, mult_ld);
        end
        dq.delete();
        lq.delete();
        ref_ptr = 0;
        repeat (30) @(negedge clk);
        vectors++;
        if (dq.size() != 0) begin
            miscompares++;
            $display("FAIL rstwait_no_done: got %0d done pulses want 0", dq.size());
        end
        m_lat = 2;
        req = 4'b1001;
        exp = ref_pick(req);
        serve(100, ok, nd, nl, d, l);
        req = 4'b0100;
        vectors++;
        if (!ok || d.v !== onehot(exp) || d.r !== 16'(ta[exp]) * 16'(tb_b[exp])) begin
            miscompares++;
            $display("FAIL rstwait_ptr: done=%b res=%h, want %b %h", d.v, d.r, onehot(exp), 16'(ta[exp]) * 16'(tb_b[exp]));
        end
        ref_ptr = (exp + 1) % NREQ;
        exp = ref_pick(req);
        serve(100, ok, nd, nl, d, l);
        req = '0;
        vectors++;
        if (!ok || d.v !== onehot(exp) || d.r !== 16'(ta[exp]) * 16'(tb_b[exp]) || d.e !== 1'b0) begin
            miscompares++;
            $display("FAIL rstwait_fresh: done=%b res=%h err=%b, want %b %h 0", d.v, d.r, d.e, onehot(exp), 16'(ta[exp]) * 16'(tb_b[exp]));
        end
        ref_ptr = (exp + 1) % NREQ;
    endtask

    task automatic test_random();
        bit ok; int nd, nl, exp, lat; done_rec_t d; ld_rec_t l;
        for (int n = 0; n < 20; n++) begin
            req = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            rand_ops();
            lat   = $urandom_range(1, 12);
            m_lat = lat;
            exp   = ref_pick(req);
            serve(100, ok, nd, nl, d, l);
            vectors++;
            if (!ok || nd != 1 || d.v !== onehot(exp)) begin
                miscompares++;
                $display("FAIL rand_grant[%0d]: req=%b done=%b pulses=%0d, want %b", n, req, d.v, nd, onehot(exp));
            end
            vectors++;
            if (d.r !== 16'(ta[exp]) * 16'(tb_b[exp]) || d.e !== 1'b0) begin
                miscompares++;
                $display("FAIL rand_res[%0d]: res=%h err=%b, want %h 0", n, d.r, d.e, 16'(ta[exp]) * 16'(tb_b[exp]));
            end
            vectors++;
            if (nl != 1 || l.a !== ta[exp] || l.b !== tb_b[exp] || d.c - l.c != lat + 1) begin
                miscompares++;
                $display("FAIL rand_load[%0d]: loads=%0d a=%h b=%h lat=%0d, want 1 %h %h %0d", n, nl, l.a, l.b, d.c - l.c, ta[exp], tb_b[exp], lat + 1);
            end
            ref_ptr = (exp + 1) % NREQ;
        end
        req = '0;
    endtask

    initial begin
        reset = 1'b1;
        req   = '0;
        op_a  = '0;
        op_b  = '0;
        test_reset();
        test_single();
        test_simultaneous();
        test_fairness();
        test_timeout();
        test_stale_ready();
        test_reset_mid_wait();
        test_random();
        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, vectors=%0d miscompares=%0d", vectors, miscompares);
        $fatal(1, "time limit");
    end

endmodule

// File: doc/mult_share_arbiter.md
Name: mult_share_arbiter

Overview:
Round-robin arbiter and sequencer that shares the single sequential 8x8 multiplier among up to NREQ requesters (colour channels, intensity scaling, future gamma stage). It captures a requester's operands, issues the one-cycle load strobe, waits for the multiplier's ready flag and returns the 16-bit product with a done pulse. A watchdog aborts any operation the multiplier never completes. It sits between the colour generator's channel engines and the multiplier, in the main clk domain.

Parameters:
NREQ, 4, number of requesters (2..8)
TIMEOUT, 32, cycles in WAIT before abort (>=2)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
req  in  NREQ  per-requester request level; held until matching done
op_a  in  8*NREQ  operand A, requester i on bits [8i+7:8i]
op_b  in  8*NREQ  operand B, same packing
gnt  out  NREQ  one-hot grant, high from LOAD through DONE
done  out  NREQ  one-cycle pulse, result valid for requester i
res  out  16  product of the granted operation; holds until next DONE
err  out  1  one-cycle pulse with done on a timeout abort
busy  out  1  high whenever state != IDLE
mult_ld  out  1  load strobe to multiplier
mult_a  out  8  multiplier operand A (registered)
mult_b  out  8  multiplier operand B (registered)
mult_rdy  in  1  multiplier result-valid flag
mult_res  in  16  multiplier product

Behaviour:
- Clock is clk; reset is synchronous, active-high, sampled on rising clk edge.
- Reset values: state=IDLE, gnt=0, done=0, res=0, err=0, busy=0, mult_ld=0, mult_a=0, mult_b=0, rr pointer=0, timeout counter=0.
- States: IDLE, LOAD, WAIT, DONE. All outputs registered.
- IDLE: if req!=0, winner = first set bit scanning from pointer upward, wrapping modulo NREQ. Register mult_a/mult_b from winner's slice, gnt=onehot(winner), go LOAD. If req==0, stay.
- LOAD: mult_ld=1 for exactly this cycle; counter cleared; go WAIT. mult_rdy ignored in LOAD (stale flag from previous op).
- WAIT: mult_ld=0. If mult_rdy=1: res<=mult_res, go DONE. Else counter++; when counter reaches TIMEOUT-1 without mult_rdy: res<=0, flag abort, go DONE.
- DONE: done[winner]=1, err=abort flag, for one cycle; gnt cleared on exit; pointer<=(winner+1) mod NREQ; go IDLE. Next arbitration occurs in the following IDLE cycle (no back-to-back from DONE).
- Latency: req sampled in IDLE at cycle t -> mult_ld at t+1 -> earliest done at t+3 (mult_rdy at t+2). Overall done = t+3+L where L = multiplier wait cycles in WAIT.
- Operands are sampled only in IDLE; later changes to op_a/op_b are ignored for that operation.
- req dropped mid-operation: operation completes, done still pulses; no cancel.
- Requester re-asserting right after done competes normally; pointer guarantees every persistent requester is served within NREQ operations.
- mult_rdy high with mult_res simultaneously at the last timeout cycle: ready wins, no err.
- Reset during any state: returns to IDLE next edge, in-flight result discarded, no done pulse.
- Pointer width ceil(log2(NREQ)); wrap handled explicitly for non-power-of-two NREQ.

Test Plan:
- Single request: req=0001, op_a[7:0]=0x12, op_b[7:0]=0x34, multiplier model ready 8 cycles after ld -> gnt=0001, one mult_ld pulse with mult_a=0x12, mult_b=0x34, done=0001 once, res=0x03A8, err=0.
- Simultaneous: req=1111 held, operands 0xFF x 0xFF on all channels -> done order 0001,0010,0100,1000,0001; each res=0xFE01; exactly one mult_ld per operation.
- Fairness: ch0 and ch2 held, ch2 requests once then drops -> sequence ch0,ch2,ch0,ch0; pointer wraps from 3 to 0 correctly.
- Timeout: model never asserts mult_rdy, TIMEOUT=32 -> done pulse and err=1 together, 32 cycles after WAIT entry, res=0; next request is served normally.
- Stale ready: mult_rdy forced high during LOAD cycle, true ready 5 cycles later with 0x1234 -> res=0x1234 (not stale value), done only after the true ready.
- Reset mid-WAIT: assert reset for 1 cycle -> next cycle gnt=0, busy=0, no done pulse; fresh req=0100 granted normally with pointer restarted at 0.
